// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcode and FSM state encodings, overflow helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
`ifndef DATA_WIDTH
`define DATA_WIDTH 4
`endif

package alu_pkg;

  localparam int DATA_WIDTH = `DATA_WIDTH;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DONE     = 2'd2
  } state_e;

  // Two's-complement overflow: operands agree in sign but the result does not.
  // For SUB the caller passes the inverted sign of B.
  function automatic logic add_ovf(input logic sign_a, input logic sign_b, input logic sign_r);
    return (sign_a == sign_b) && (sign_r != sign_a);
  endfunction

endpackage

// File: rtl/alu_mc_mul.sv
// Unsigned shift-add multiplier, one partial product per cycle.
// Latency: done pulses WIDTH cycles after the start edge; prod is valid while done is high and after.
// Backpressure: none; start while busy is ignored.
module mul_shift_add #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH + 1);

  logic               busy_q;
  logic               done_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;

  // Load operands on start, then add one shifted multiplicand per cycle for WIDTH cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (!busy_q) begin
        if (start) begin
          busy_q   <= 1'b1;
          cnt_q    <= '0;
          acc_q    <= '0;
          mcand_q  <= {{WIDTH{1'b0}}, a};
          mplier_q <= b;
        end
      end else begin
        if (mplier_q[0]) begin
          acc_q <= acc_q + mcand_q;
        end
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done = done_q;
  assign prod = acc_q;

endmodule

// File: rtl/alu_mc.sv
// Sequential ALU with opcode select, registered result/flags and valid/ready on both sides.
// Latency: 1 cycle for ADD/SUB/logic/shift ops, WIDTH+1 cycles for MUL.
// Backpressure: result held while out_ready is low; in_ready drops until the result drains.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::DATA_WIDTH,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             c,
  output logic             z,
  output logic             n,
  output logic             v
);

  localparam int SW = $clog2(WIDTH);

  state_e           state_q;
  logic             rdy_en_q;
  logic [WIDTH-1:0] out_q;
  logic             c_q, z_q, n_q, v_q;

  logic             accept;
  logic             is_mul;
  logic             mul_done;
  logic [2*WIDTH-1:0] prod;

  logic [SW-1:0]    sh;
  logic [WIDTH:0]   sum_w, diff_w, shl_w, shr_w;
  logic [WIDTH-1:0] res_d;
  logic             c_d, v_d;

  // in_ready is held low through reset and the first cycle after release.
  assign in_ready  = rdy_en_q && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign is_mul    = (op_e'(op) == OP_MUL);
  assign out_valid = (state_q == DONE);

  // The multiplier captures its own copy of the operands, so later input changes are ignored.
  mul_shift_add #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && is_mul),
    .a     (ain),
    .b     (bin),
    .done  (mul_done),
    .prod  (prod)
  );

  // Extra top bit carries the carry/borrow or the last bit shifted out.
  assign sh     = bin[SW-1:0];
  assign sum_w  = {1'b0, ain} + {1'b0, bin};
  assign diff_w = {1'b0, ain} - {1'b0, bin};
  assign shl_w  = {1'b0, ain} << sh;
  assign shr_w  = {ain, 1'b0} >> sh;

  // Single-cycle result and carry/overflow for the opcode at the input.
  always_comb begin
    res_d = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        res_d = sum_w[WIDTH-1:0];
        c_d   = sum_w[WIDTH];
        v_d   = add_ovf(ain[WIDTH-1], bin[WIDTH-1], sum_w[WIDTH-1]);
      end
      OP_SUB: begin
        res_d = diff_w[WIDTH-1:0];
        c_d   = diff_w[WIDTH];
        v_d   = add_ovf(ain[WIDTH-1], ~bin[WIDTH-1], diff_w[WIDTH-1]);
      end
      OP_AND: res_d = ain & bin;
      OP_OR:  res_d = ain | bin;
      OP_XOR: res_d = ain ^ bin;
      OP_SHL: begin
        res_d = shl_w[WIDTH-1:0];
        c_d   = shl_w[WIDTH];
      end
      OP_SHR: begin
        res_d = shr_w[WIDTH:1];
        c_d   = shr_w[0];
      end
      default: begin
        res_d = '0;
      end
    endcase
  end

  // Control FSM with registered result and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rdy_en_q <= 1'b0;
      out_q    <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      if (accept) begin
        if (is_mul) begin
          state_q <= MUL_BUSY;
        end else begin
          state_q <= DONE;
          out_q   <= res_d;
          c_q     <= c_d;
          z_q     <= (res_d == '0);
          n_q     <= res_d[WIDTH-1];
          v_q     <= v_d;
        end
      end else begin
        case (state_q)
          MUL_BUSY: begin
            if (mul_done) begin
              state_q <= DONE;
              out_q   <= prod[WIDTH-1:0];
              c_q     <= |prod[2*WIDTH-1:WIDTH];
              z_q     <= (prod[WIDTH-1:0] == '0);
              n_q     <= prod[WIDTH-1];
              v_q     <= 1'b0;
            end
          end
          DONE: begin
            if (out_ready) begin
              state_q <= IDLE;
            end
          end
          default: begin
            state_q <= state_q;
          end
        endcase
      end
    end
  end

  assign out = out_q;
  assign c   = c_q;
  assign z   = z_q;
  assign n   = n_q;
  assign v   = v_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed corner cases plus a randomized stream against an arithmetic model.
// Inputs are driven and outputs sampled on the falling clock edge.
// Scoreboard queue tracks accepted ops through random backpressure.
module tb_alu_mc;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] ain;
  logic [W-1:0] bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         c, z, n, v;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] sbq[$];

  alu_mc #(.WIDTH(W), .OPW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .ain       (ain),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .c         (c),
    .z         (z),
    .n         (n),
    .v         (v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] vec();
    return 32'({out, c, z, n, v});
  endfunction

  function automatic logic [31:0] pk(input logic [W-1:0] o, input logic cc, input logic zz,
                                     input logic nn, input logic vv);
    return 32'({o, cc, zz, nn, vv});
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic logic [31:0] model(input int opc, input int a, input int b);
    int m, h, o, cc, vv, s, sa, sb, r, sh, zz, nn;
    m  = 1 << W;
    h  = m / 2;
    o  = 0;
    cc = 0;
    vv = 0;
    sa = (a >= h) ? a - m : a;
    sb = (b >= h) ? b - m : b;
    sh = b % W;
    case (opc)
      0: begin s = a + b; o = s % m; cc = (s >= m) ? 1 : 0; r = sa + sb; vv = (r >= h || r < -h) ? 1 : 0; end
      1: begin s = a - b; o = (s + m) % m; cc = (a < b) ? 1 : 0; r = sa - sb; vv = (r >= h || r < -h) ? 1 : 0; end
      2: o = a & b;
      3: o = a | b;
      4: o = a ^ b;
      5: begin o = (a << sh) % m; cc = (sh == 0) ? 0 : ((a >> (W - sh)) & 1); end
      6: begin o = a >> sh; cc = (sh == 0) ? 0 : ((a >> (sh - 1)) & 1); end
      default: begin s = a * b; o = s % m; cc = (s >= m) ? 1 : 0; end
    endcase
    zz = (o == 0) ? 1 : 0;
    nn = (o >= h) ? 1 : 0;
    return 32'((o << 4) | (cc << 3) | (zz << 2) | (nn << 1) | vv);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_rdy();
    int k;
    k = 0;
    while (in_ready !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    chk("in_ready wait", 32'(in_ready), 32'd1);
  endtask

  task automatic do1(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [31:0] exp);
    out_ready = 1'b1;
    wait_rdy();
    op = o; ain = a; bin = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, " vld"}, 32'(out_valid), 32'd1);
    chk(tag, vec(), exp);
  endtask

  initial begin
    logic [31:0] exp_prev;
    logic [31:0] hold_v;
    logic        hold_f;
    logic        seen;

    // Reset state
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; ain = '0; bin = '0;
    #1;
    chk("reset vld", 32'(out_valid), 32'd0);
    chk("reset res", vec(), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("in_ready before first edge", 32'(in_ready), 32'd0);
    @(negedge clk);
    tick();
    chk("in_ready after release", 32'(in_ready), 32'd1);

    // Directed arithmetic corners
    do1("add wrap",  3'd0, 4'b1111, 4'b0001, pk(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0));
    do1("add ovf",   3'd0, 4'b0111, 4'b0001, pk(4'b1000, 1'b0, 1'b0, 1'b1, 1'b1));
    do1("sub borrow",3'd1, 4'b0000, 4'b0001, pk(4'b1111, 1'b1, 1'b0, 1'b1, 1'b0));
    do1("shl 1",     3'd5, 4'b1001, 4'b0001, pk(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0));
    do1("shr 2",     3'd6, 4'b0011, 4'b0010, pk(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0));
    do1("shl 0",     3'd5, 4'b1011, 4'b0100, pk(4'b1011, 1'b0, 1'b0, 1'b1, 1'b0));

    // MUL latency and busy behaviour; operand changes after accept are ignored
    out_ready = 1'b1;
    wait_rdy();
    op = 3'd7; ain = 4'b1111; bin = 4'b1111; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; ain = 4'b0011; bin = 4'b0000;
    for (int k = 0; k < W + 1; k++) begin
      chk($sformatf("mul busy vld %0d", k), 32'(out_valid), 32'd0);
      chk($sformatf("mul busy rdy %0d", k), 32'(in_ready), 32'd0);
      tick();
    end
    chk("mul vld", 32'(out_valid), 32'd1);
    chk("mul res", vec(), pk(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0));
    tick();

    // Reset during MUL aborts it
    wait_rdy();
    op = 3'd7; ain = 4'b0111; bin = 4'b0011; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid reset vld", 32'(out_valid), 32'd0);
    chk("mid reset res", vec(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < W + 4; k++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("aborted mul emits nothing", 32'(seen), 32'd0);
    chk("in_ready after mid reset", 32'(in_ready), 32'd1);

    // Backpressure: result held, then drain and accept together
    out_ready = 1'b0;
    wait_rdy();
    op = 3'd4; ain = 4'b0110; bin = 4'b0011; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp hold %0d", k), vec(), pk(4'b0101, 1'b0, 1'b0, 1'b0, 1'b0));
      chk($sformatf("bp vld %0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp rdy %0d", k), 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    op = 3'd2; ain = 4'b1100; bin = 4'b1010; in_valid = 1'b1;
    #1;
    chk("bp drain rdy", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp next vld", 32'(out_valid), 32'd1);
    chk("bp next res", vec(), pk(4'b1000, 1'b0, 1'b0, 1'b1, 1'b0));
    tick();

    // Back-to-back single-cycle ops
    out_ready = 1'b1;
    exp_prev = '0;
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin
        chk($sformatf("b2b vld %0d", i), 32'(out_valid), 32'd1);
        chk($sformatf("b2b res %0d", i), vec(), exp_prev);
      end
      if (i < 4) begin
        op = 3'($urandom_range(0, 6)); ain = W'($urandom); bin = W'($urandom);
        in_valid = 1'b1;
        #1;
        chk($sformatf("b2b rdy %0d", i), 32'(in_ready), 32'd1);
        exp_prev = model(int'(op), int'(ain), int'(bin));
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end

    // Randomized stream with random backpressure and a scoreboard
    hold_f = 1'b0;
    hold_v = '0;
    for (int i = 0; i < 400; i++) begin
      if (hold_f) begin
        chk("stream hold vld", 32'(out_valid), 32'd1);
        chk("stream hold res", vec(), hold_v);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = 1'($urandom_range(0, 1));
      op  = 3'($urandom_range(0, 7));
      ain = W'($urandom);
      bin = W'($urandom);
      #1;
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) chk("stream spurious", 32'(out_valid), 32'd0);
        else chk("stream res", vec(), sbq.pop_front());
      end
      if (in_valid && in_ready) sbq.push_back(model(int'(op), int'(ain), int'(bin)));
      hold_f = out_valid && !out_ready;
      hold_v = vec();
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3 * W && sbq.size() != 0; i++) begin
      #1;
      if (out_valid) chk("drain res", vec(), sbq.pop_front());
      tick();
    end
    chk("scoreboard empty", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
